pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Instruction-fetch sequencer and program counter sitting directly downstream of the condition-code/branch FSM. It fetches each instruction through a ready handshake, holds it in the instruction register, and presents it to decode. It then applies that FSM's branch-taken decision (`pc_ctl_0`) or a register jump to the PC before the next fetch.

## Interface
- `WIDTH`, 16: PC, instruction and base-register width.
- `RESET_VECTOR`, 16'h3000: PC value loaded on reset.
- `clka`  input  1: sole clock; all state updates on posedge.
- `reset_in`  input  1: asynchronous, active-high reset.
- `instr_in`  input  WIDTH: instruction word from instruction memory.
- `mem_ready_in`  input  1: memory has valid `instr_in` this cycle.
- `stall_in`  input  1: hold in EXEC while high.
- `pc_ctl_0_in`  input  1: branch taken, from the condition-code FSM.
- `jmp_in`  input  1: current instruction is a register jump.
- `base_in`  input  WIDTH: jump target register value.
- `offset9_in`  input  9: two's-complement branch offset (IR[8:0]).
- `fetch_req_out`  output  1: fetch request, equal to state==FETCH.
- `pc_out`  output  WIDTH: program counter, also the fetch address.
- `ir_out`  output  WIDTH: instruction register.
- `ir_valid_out`  output  1: single-cycle pulse, high in DECODE.
- `state_out`  output  2: current state encoding.

## Operation
- States: FETCH=2'b00, DECODE=2'b01, EXEC=2'b10, UPDATE=2'b11.
- FETCH: `fetch_req_out`=1. Stay while `mem_ready_in`=0. When `mem_ready_in`=1: `ir_out`<=`instr_in`, `pc_out`<=`pc_out`+1, go to DECODE.
- DECODE: `ir_valid_out`=1 for exactly this cycle. Go to EXEC.
- EXEC: stay while `stall_in`=1. When `stall_in`=0, go to UPDATE.
- UPDATE: priority is `jmp_in` > `pc_ctl_0_in`.
  - `jmp_in`=1: `pc_out`<=`base_in`.
  - Else `pc_ctl_0_in`=1: `pc_out`<=`pc_out`+sext(`offset9_in`), using the already-incremented PC.
  - Else: `pc_out` holds.
  - In all cases, go to FETCH.
- Arithmetic: sext to WIDTH bits, sum truncated mod 2^WIDTH. 16'hFFFF+1 wraps to 16'h0000. Negative offsets wrap below 0.
- Inputs other than `mem_ready_in` and `instr_in` are ignored outside the states listed above. `jmp_in`, `pc_ctl_0_in` and `offset9_in` are sampled only in UPDATE.

## Timing
- Reset values (asynchronous, immediate): state=FETCH, `pc_out`=RESET_VECTOR, `ir_out`=0, `ir_valid_out`=0, `fetch_req_out`=1, `state_out`=2'b00.
- First posedge after reset deasserts with `mem_ready_in`=1: IR is loaded.
- Minimum instruction period is 4 cycles (FETCH, DECODE, EXEC, UPDATE). Each extra cycle of `mem_ready_in`=0 or `stall_in`=1 adds one cycle.
- `pc_out` changes only on the FETCH→DECODE edge and the UPDATE→FETCH edge.
- `mem_ready_in` asserted outside FETCH is ignored; IR is not overwritten.
- `pc_ctl_0_in` must be stable in the UPDATE cycle. The upstream FSM resolves it during EXEC.
- Reset asserted mid-operation, in any state: immediate return to reset values. Any in-flight fetch or pending branch is discarded.

## Structure
- Shared package holds:
  - the state encodings FETCH/DECODE/EXEC/UPDATE;
  - the default reset vector 16'h3000;
  - a `sext9` function, shared with the decoder.
- One natural sub-module: `pc_adder`, a combinational WIDTH-bit adder for both PC+1 and PC+sext(offset). It is instantiated once, with an operand mux selected by state.
- FSM and registers live in `pc_sequencer`. No other hierarchy.

## Test plan
- Reset, then `mem_ready_in`=1 constantly, `instr_in`=16'h1234, no branch or jump:
  - `ir_out`=16'h1234 after cycle 1;
  - `pc_out` = 3000, 3001, 3002… with one increment every 4 cycles;
  - `ir_valid_out` pulses every 4th cycle.
- Branch taken: PC=16'h3000, `offset9_in`=9'h1FE (−2), `pc_ctl_0_in`=1 in UPDATE → next fetch address is 16'h2FFF.
- Jump priority: `jmp_in`=1, `pc_ctl_0_in`=1, `base_in`=16'h4000 in UPDATE → `pc_out`=16'h4000.
- Wrap: RESET_VECTOR=16'hFFFF, fetch completes → `pc_out`=16'h0000. Then offset 9'h0FF (+255) taken → 16'h00FF.
- Handshake and stall:
  - `mem_ready_in` low for 3 cycles → `fetch_req_out` held high, `ir_out` unchanged, `pc_out` unchanged;
  - `stall_in` high for 2 cycles in EXEC → 6-cycle instruction period.
- Reset mid-EXEC with a pending taken branch → `pc_out`=RESET_VECTOR immediately, state=FETCH, and the branch is never applied.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// rtl/pc_sequencer_pkg.sv - shared state encodings, reset vector and offset sign-extension
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    FETCH  = 2'b00,
    DECODE = 2'b01,
    EXEC   = 2'b10,
    UPDATE = 2'b11
  } pc_state_t;

  localparam logic [15:0] DEFAULT_RESET_VECTOR = 16'h3000;

  // Returned wide so callers of any width up to 32 can truncate with a cast.
  function automatic logic [31:0] sext9(input logic [8:0] value);
    return {{23{value[8]}}, value};
  endfunction

endpackage

// File: rtl/pc_adder.sv
// rtl/pc_adder.sv - combinational PC adder shared by increment and branch-offset paths
module pc_adder #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - instruction-fetch FSM, program counter and instruction register
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int               WIDTH        = 16,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEFAULT_RESET_VECTOR)
) (
  input  logic             clka,
  input  logic             reset_in,
  input  logic [WIDTH-1:0] instr_in,
  input  logic             mem_ready_in,
  input  logic             stall_in,
  input  logic             pc_ctl_0_in,
  input  logic             jmp_in,
  input  logic [WIDTH-1:0] base_in,
  input  logic [8:0]       offset9_in,
  output logic             fetch_req_out,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] ir_out,
  output logic             ir_valid_out,
  output logic [1:0]       state_out
);

  pc_state_t        state;
  pc_state_t        next_state;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] ir;
  logic [WIDTH-1:0] add_b;
  logic [WIDTH-1:0] add_sum;

  // One adder: +1 while fetching, +sext(offset) in UPDATE on the already-incremented PC.
  assign add_b = (state == UPDATE) ? WIDTH'(sext9(offset9_in))
                                   : {{(WIDTH-1){1'b0}}, 1'b1};

  pc_adder #(.WIDTH(WIDTH)) u_pc_adder (
    .a   (pc),
    .b   (add_b),
    .sum (add_sum)
  );

  always_ff @(posedge clka or posedge reset_in) begin
    if (reset_in) begin
      state <= FETCH;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state    = state;
    fetch_req_out = 1'b0;
    ir_valid_out  = 1'b0;
    case (state)
      FETCH: begin
        fetch_req_out = 1'b1;
        if (mem_ready_in) begin
          next_state = DECODE;
        end
      end
      DECODE: begin
        ir_valid_out = 1'b1;
        next_state   = EXEC;
      end
      EXEC: begin
        if (!stall_in) begin
          next_state = UPDATE;
        end
      end
      UPDATE: begin
        next_state = FETCH;
      end
      default: begin
        next_state = FETCH;
      end
    endcase
  end

  always_ff @(posedge clka or posedge reset_in) begin
    if (reset_in) begin
      pc <= RESET_VECTOR;
      ir <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (mem_ready_in) begin
            ir <= instr_in;
            pc <= add_sum;
          end
        end
        UPDATE: begin
          if (jmp_in) begin
            pc <= base_in;
          end else if (pc_ctl_0_in) begin
            pc <= add_sum;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign pc_out    = pc;
  assign ir_out    = ir;
  assign state_out = state;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - instruction-level reference checks of pc_sequencer, two reset vectors
module tb_pc_sequencer;

  logic        clka = 1'b0;
  logic        reset_in;
  logic [15:0] instr_in;
  logic        mem_ready_in;
  logic        stall_in;
  logic        pc_ctl_0_in;
  logic        jmp_in;
  logic [15:0] base_in;
  logic [8:0]  offset9_in;

  logic        fetch_req, fetch_req_w;
  logic [15:0] pc, pc_w;
  logic [15:0] ir, ir_w;
  logic        ir_valid, ir_valid_w;
  logic [1:0]  state, state_w;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] pc_m, pc_wm, ir_m;

  always #5 clka = ~clka;

  pc_sequencer dut (
    .clka(clka), .reset_in(reset_in), .instr_in(instr_in), .mem_ready_in(mem_ready_in),
    .stall_in(stall_in), .pc_ctl_0_in(pc_ctl_0_in), .jmp_in(jmp_in), .base_in(base_in),
    .offset9_in(offset9_in), .fetch_req_out(fetch_req), .pc_out(pc), .ir_out(ir),
    .ir_valid_out(ir_valid), .state_out(state)
  );

  pc_sequencer #(.WIDTH(16), .RESET_VECTOR(16'hFFFF)) dut_w (
    .clka(clka), .reset_in(reset_in), .instr_in(instr_in), .mem_ready_in(mem_ready_in),
    .stall_in(stall_in), .pc_ctl_0_in(pc_ctl_0_in), .jmp_in(jmp_in), .base_in(base_in),
    .offset9_in(offset9_in), .fetch_req_out(fetch_req_w), .pc_out(pc_w), .ir_out(ir_w),
    .ir_valid_out(ir_valid_w), .state_out(state_w)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clka);
    #1;
  endtask

  function automatic logic [15:0] branch_target(input logic [15:0] base_pc, input logic [8:0] off);
    int delta;
    delta = off[8] ? int'(off) - 512 : int'(off);
    return 16'(int'(base_pc) + delta);
  endfunction

  // st: 0 fetch, 1 decode, 2 exec, 3 update
  task automatic check_outs(input string tag, input int st);
    check({tag, ".state"},     32'(state),      32'(st));
    check({tag, ".state_w"},   32'(state_w),    32'(st));
    check({tag, ".fetch_req"}, 32'(fetch_req),  32'(st == 0));
    check({tag, ".ir_valid"},  32'(ir_valid),   32'(st == 1));
    check({tag, ".ir_valid_w"},32'(ir_valid_w), 32'(st == 1));
    check({tag, ".pc"},        32'(pc),         32'(pc_m));
    check({tag, ".pc_w"},      32'(pc_w),       32'(pc_wm));
    check({tag, ".ir"},        32'(ir),         32'(ir_m));
    check({tag, ".ir_w"},      32'(ir_w),       32'(ir_m));
  endtask

  task automatic scramble_ignored();
    jmp_in      = 1'($urandom);
    pc_ctl_0_in = 1'($urandom);
    base_in     = 16'($urandom);
    offset9_in  = 9'($urandom);
  endtask

  task automatic do_reset();
    reset_in = 1'b1;
    #2;
    pc_m = 16'h3000; pc_wm = 16'hFFFF; ir_m = 16'h0000;
    check_outs("reset_async", 0);
    step();
    step();
    reset_in = 1'b0;
    check_outs("reset", 0);
  endtask

  task automatic do_instr(input logic [15:0] instr, input int waits, input int stalls,
                          input bit jmp, input bit br, input logic [15:0] base,
                          input logic [8:0] off);
    check_outs("fetch", 0);
    repeat (waits) begin
      mem_ready_in = 1'b0;
      instr_in     = 16'($urandom);
      stall_in     = 1'($urandom);
      scramble_ignored();
      step();
      check_outs("fetch_wait", 0);
    end
    mem_ready_in = 1'b1;
    instr_in     = instr;
    step();
    ir_m  = instr;
    pc_m  = pc_m + 16'd1;
    pc_wm = pc_wm + 16'd1;
    check_outs("decode", 1);
    mem_ready_in = 1'($urandom);
    instr_in     = 16'($urandom);
    stall_in     = 1'($urandom);
    scramble_ignored();
    step();
    check_outs("exec", 2);
    repeat (stalls) begin
      stall_in     = 1'b1;
      mem_ready_in = 1'($urandom);
      scramble_ignored();
      step();
      check_outs("stall", 2);
    end
    stall_in = 1'b0;
    step();
    check_outs("update", 3);
    jmp_in       = jmp;
    pc_ctl_0_in  = br;
    base_in      = base;
    offset9_in   = off;
    mem_ready_in = 1'($urandom);
    step();
    if (jmp) begin
      pc_m  = base;
      pc_wm = base;
    end else if (br) begin
      pc_m  = branch_target(pc_m, off);
      pc_wm = branch_target(pc_wm, off);
    end
    check_outs("next_fetch", 0);
  endtask

  initial begin
    reset_in = 1'b1; instr_in = '0; mem_ready_in = 1'b0; stall_in = 1'b0;
    pc_ctl_0_in = 1'b0; jmp_in = 1'b0; base_in = '0; offset9_in = '0;
    do_reset();

    // steady stream of 16'h1234, no control flow
    for (int i = 0; i < 3; i++) do_instr(16'h1234, 0, 0, 0, 0, 16'h0, 9'h0);
    check("stream.pc", 32'(pc), 32'h3003);
    check("stream.pc_w", 32'(pc_w), 32'h0002);
    check("stream.ir", 32'(ir), 32'h1234);

    // +255 taken: wrap instance goes FFFF -> 0000 -> 00FF
    do_reset();
    do_instr(16'h1234, 0, 0, 0, 1, 16'h0, 9'h0FF);
    check("wrap_br.pc_w", 32'(pc_w), 32'h00FF);
    check("wrap_br.pc", 32'(pc), 32'h3100);

    // -2 taken from 3000
    do_reset();
    do_instr(16'h0A0A, 0, 0, 0, 1, 16'h0, 9'h1FE);
    check("br_neg.pc", 32'(pc), 32'h2FFF);

    // jump wins over branch
    do_instr(16'h5555, 0, 0, 1, 1, 16'h4000, 9'h010);
    check("jmp_prio.pc", 32'(pc), 32'h4000);
    check("jmp_prio.pc_w", 32'(pc_w), 32'h4000);

    // 3 cycles of memory wait and 2 cycles of stall
    do_instr(16'hBEEF, 3, 0, 0, 0, 16'h0, 9'h0);
    do_instr(16'hCAFE, 0, 2, 0, 0, 16'h0, 9'h0);
    check("hs_stall.pc", 32'(pc), 32'h4002);

    // reset in EXEC with a taken branch pending
    mem_ready_in = 1'b1; instr_in = 16'h7777;
    step();
    mem_ready_in = 1'b0; stall_in = 1'b1; pc_ctl_0_in = 1'b1; offset9_in = 9'h040;
    step();
    check("pre_reset.state", 32'(state), 32'h2);
    #2;
    reset_in = 1'b1;
    #1;
    check("mid_reset.pc", 32'(pc), 32'h3000);
    check("mid_reset.state", 32'(state), 32'h0);
    check("mid_reset.ir", 32'(ir), 32'h0000);
    step();
    reset_in = 1'b0; stall_in = 1'b0; pc_ctl_0_in = 1'b0;
    pc_m = 16'h3000; pc_wm = 16'hFFFF; ir_m = 16'h0000;
    do_instr(16'h1111, 0, 0, 0, 0, 16'h0, 9'h0);
    check("post_reset.pc", 32'(pc), 32'h3001);

    for (int i = 0; i < 300; i++) begin
      do_instr(16'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               ($urandom_range(0, 3) == 0), 1'($urandom), 16'($urandom), 9'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
